// File: rtl/wave_generator.sv
// Sample-rate waveform generator: a 32-bit phase accumulator advanced once per DIV clocks,
// shaped into square, sawtooth, triangle or quarter-wave-ROM sine as a 10-bit PWM duty value.
module wave_generator #(
  parameter logic [31:0] CLKFREQ = 32'd10000000,
  parameter logic [31:0] FREQ    = 32'd200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  wave_sel,
  input  logic [31:0] tune_word,
  input  logic        tune_load,
  output logic [9:0]  value,
  output logic        sample_valid
);

  localparam int unsigned DIV  = CLKFREQ / FREQ;
  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic [31:0]     phase_q;
  logic [31:0]     tune_q;
  logic            tick;
  logic [9:0]      p;
  logic [7:0]      idx;
  logic [8:0]      mag;
  logic [9:0]      wave;
  logic [8:0]      sine_rom [256];

  // Elaboration-time round(511*sin(pi/2*(i+0.5)/256)) via a Q30 fixed-point Taylor series.
  function automatic logic [8:0] sine_mag(input int unsigned i);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (64'sd3373259426 * longint'(2 * i + 1)) / 64'sd1024;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'(2 * k * (2 * k + 1));
      sum  = sum + term;
    end
    return 9'((64'sd511 * sum + (64'sd1 <<< 29)) >>> 30);
  endfunction

  for (genvar g = 0; g < 256; g++) begin : g_rom
    localparam logic [8:0] Mag = sine_mag(g);
    assign sine_rom[g] = Mag;
  end

  assign tick = en && (cnt_q == CntMax);
  assign p    = phase_q[31:22];

  always_comb begin
    idx  = p[8] ? ~p[7:0] : p[7:0];
    mag  = sine_rom[idx];
    wave = '0;
    case (wave_sel)
      2'd0:    wave = p[9] ? 10'd0 : 10'd1023;
      2'd1:    wave = p;
      2'd2:    wave = p[9] ? (10'd1023 - {p[8:0], 1'b0}) : {p[8:0], 1'b0};
      default: wave = p[9] ? (10'd511 - {1'b0, mag}) : (10'd512 + {1'b0, mag});
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      phase_q      <= '0;
      tune_q       <= '0;
      value        <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= tick;
      if (en) begin
        cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        // Phase update below reads the old tune_q, so a load on a tick takes effect next tick.
        if (tune_load) tune_q <= tune_word;
      end
      if (tick) begin
        value   <= wave;
        phase_q <= phase_q + tune_q;
      end
    end
  end

endmodule

// File: tb/tb_wave_generator.sv
// Directed and randomized bench for wave_generator, checked every edge against a sample-level
// model plus directed sequences with hand-derived expected values.
module tb_wave_generator;

  localparam int DIV = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  wave_sel;
  logic [31:0] tune_word;
  logic        tune_load;
  logic [9:0]  value;
  logic        sample_valid;

  int tests = 0;
  int fails = 0;

  int unsigned m_en_cycles;
  logic [31:0] m_phase;
  logic [31:0] m_tune;
  logic [9:0]  m_val;
  logic        m_sv;

  int sine_exp [4] = '{514, 1023, 509, 0};

  wave_generator dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .wave_sel    (wave_sel),
    .tune_word   (tune_word),
    .tune_load   (tune_load),
    .value       (value),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  function automatic int ref_wave(input logic [1:0] sel, input int p);
    real s;
    int  m;
    case (sel)
      2'd0: return (p < 512) ? 1023 : 0;
      2'd1: return p;
      2'd2: return (p < 512) ? 2 * p : 1023 - 2 * (p - 512);
      default: begin
        s = $sin(2.0 * 3.14159265358979 * (p + 0.5) / 1024.0);
        if (p < 512) begin
          m = $rtoi(511.0 * s + 0.5);
          return 512 + m;
        end
        m = $rtoi(-511.0 * s + 0.5);
        return 511 - m;
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge: advance the model on the inputs present at the edge, then compare.
  task automatic edge_step();
    @(posedge clk);
    if (rst) begin
      m_en_cycles = 0;
      m_phase     = '0;
      m_tune      = '0;
      m_val       = '0;
      m_sv        = 1'b0;
    end else if (en) begin
      m_en_cycles++;
      m_sv = (m_en_cycles % DIV == 0);
      if (m_sv) begin
        m_val   = 10'(ref_wave(wave_sel, int'(m_phase[31:22])));
        m_phase = m_phase + m_tune;
      end
      if (tune_load) m_tune = tune_word;
    end else begin
      m_sv = 1'b0;
    end
    #1;
    check("sample_valid", 32'(sample_valid), 32'(m_sv));
    check("value", 32'(value), 32'(m_val));
  endtask

  task automatic wait_pulse(output int edges, output logic [9:0] v);
    edges = 0;
    do begin
      edge_step();
      edges++;
    end while (sample_valid !== 1'b1 && edges < 4 * DIV);
    if (sample_valid !== 1'b1) check("pulse_timeout", 32'd0, 32'd1);
    v = value;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    tune_load = 1'b0;
    edge_step();
    check("reset_value", 32'(value), 32'd0);
    check("reset_valid", 32'(sample_valid), 32'd0);
    rst = 1'b0;
  endtask

  task automatic start(input logic [1:0] sel, input logic [31:0] tw);
    wave_sel  = sel;
    tune_word = tw;
    en        = 1'b1;
    tune_load = 1'b1;
    edge_step();
    tune_load = 1'b0;
  endtask

  initial begin
    int         n;
    int         p;
    int         pulses;
    logic [9:0] v;

    rst       = 1'b1;
    en        = 1'b0;
    tune_load = 1'b0;
    wave_sel  = 2'd0;
    tune_word = '0;
    edge_step();
    do_reset();

    // Sawtooth: first pulse on the 50th edge after release, then +4 per sample.
    start(2'd1, 32'h0100_0000);
    wait_pulse(n, v);
    check("saw_first_edge", 32'(n + 1), 32'd50);
    check("saw_first_val", 32'(v), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      wait_pulse(n, v);
      check("saw_spacing", 32'(n), 32'(DIV));
      check("saw_val", 32'(v), 32'(4 * k));
    end

    // Square at half-cycle increment.
    do_reset();
    start(2'd0, 32'h8000_0000);
    for (int k = 0; k < 6; k++) begin
      wait_pulse(n, v);
      check("square_val", 32'(v), (k % 2 == 0) ? 32'd1023 : 32'd0);
    end

    // Triangle over a full phase wrap.
    do_reset();
    start(2'd2, 32'h0040_0000);
    for (int k = 0; k <= 1024; k++) begin
      wait_pulse(n, v);
      p = k % 1024;
      check("triangle_val", 32'(v), (p < 512) ? 32'(2 * p) : 32'(1023 - 2 * (p - 512)));
    end

    // Sine at quarter-cycle increment.
    do_reset();
    start(2'd3, 32'h4000_0000);
    for (int k = 0; k < 8; k++) begin
      wait_pulse(n, v);
      check("sine_val", 32'(v), 32'(sine_exp[k % 4]));
    end

    // tune_load on the tick edge: that tick still advances by the old increment.
    do_reset();
    start(2'd1, 32'h0100_0000);
    for (int k = 2; k < DIV; k++) edge_step();
    tune_word = 32'h0200_0000;
    tune_load = 1'b1;
    edge_step();
    tune_load = 1'b0;
    check("coinc_pulse", 32'(sample_valid), 32'd1);
    check("coinc_val0", 32'(value), 32'd0);
    wait_pulse(n, v);
    check("coinc_old_inc", 32'(v), 32'd4);
    wait_pulse(n, v);
    check("coinc_new_inc", 32'(v), 32'd12);

    // en=0 for 200 clocks: no pulses, value held, counter resumes where it stopped.
    for (int k = 0; k < 10; k++) edge_step();
    en     = 1'b0;
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      edge_step();
      if (sample_valid === 1'b1) pulses++;
    end
    check("en0_pulses", 32'(pulses), 32'd0);
    check("en0_hold", 32'(value), 32'd12);
    en = 1'b1;
    wait_pulse(n, v);
    check("en0_resume_edges", 32'(n), 32'(DIV - 10));
    check("en0_resume_val", 32'(v), 32'd20);

    // Reset mid-period with en held high.
    for (int k = 0; k < 20; k++) edge_step();
    rst = 1'b1;
    edge_step();
    check("midrst_value", 32'(value), 32'd0);
    check("midrst_valid", 32'(sample_valid), 32'd0);
    rst = 1'b0;
    wait_pulse(n, v);
    check("midrst_edges", 32'(n), 32'(DIV));
    check("midrst_val", 32'(v), 32'd0);

    // Randomized: shape changes between ticks, reloads (sometimes on ticks), en gaps, resets.
    do_reset();
    start(2'($urandom_range(3)), $urandom);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(39) == 0) wave_sel = 2'($urandom_range(3));
      if ($urandom_range(149) == 0) en = ~en;
      tune_word = $urandom;
      tune_load = en && ($urandom_range(59) == 0);
      rst       = ($urandom_range(999) == 0);
      edge_step();
    end
    rst       = 1'b0;
    tune_load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
